// File: rtl/ahb_arbiter_slave_3_pkg.sv
// rtl/ahb_arbiter_slave_3_pkg.sv - shared types and defaults for the slave_3 round-robin arbiter
package AHB_package;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

    localparam int ARB_MAX_HOLD_DEF = 4;

endpackage

// File: rtl/ahb_arbiter_slave_3_picker.sv
// rtl/ahb_arbiter_slave_3_picker.sv - combinational round-robin pick starting after i_last_ptr
module ahb_rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_last_ptr,
    output logic [N-1:0]  o_winner,
    output logic [PW-1:0] o_winner_idx,
    output logic          o_valid
);

    logic [PW-1:0] w_scan;

    // Scan last_ptr+1 .. last_ptr (wrapping); last_ptr itself is checked last.
    always_comb begin
        o_winner     = '0;
        o_winner_idx = '0;
        o_valid      = 1'b0;
        w_scan       = '0;
        for (int k = 1; k <= N; k++) begin
            w_scan = PW'((int'(i_last_ptr) + k) % N);
            if (!o_valid && i_req[w_scan]) begin
                o_valid          = 1'b1;
                o_winner[w_scan] = 1'b1;
                o_winner_idx     = w_scan;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_slave_3.sv
// rtl/ahb_arbiter_slave_3.sv - round-robin arbiter for the master->slave_3 path (option: AHB_ARB_HOLD_LIMIT_EN)
module ahb_arbiter_slave_3
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int MAX_HOLD    = ARB_MAX_HOLD_DEF
) (
    input  logic                   hclk,
    input  logic                   hreset_n,
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [CHANNEL_NUM-1:0] lock,
    input  logic                   hready,
    output logic [CHANNEL_NUM-1:0] sel_addr,
    output logic [CHANNEL_NUM-1:0] sel_data,
    output logic                   grant_valid
);

    localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    arb_state_e             r_state;
    logic [PW-1:0]          r_last_ptr;
    logic [CHANNEL_NUM-1:0] r_sel_addr;
    logic [CHANNEL_NUM-1:0] r_sel_data;

    logic [CHANNEL_NUM-1:0] w_cand_req;
    logic [CHANNEL_NUM-1:0] w_pick;
    logic [PW-1:0]          w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_own_req;
    logic                   w_own_lock;

    // In OWN, r_sel_addr is the owner one-hot, so it doubles as the owner mask.
    assign w_cand_req = req & ~r_sel_addr;
    assign w_own_req  = |(req & r_sel_addr);
    assign w_own_lock = |(lock & r_sel_addr);

    ahb_rr_picker #(
        .N  (CHANNEL_NUM),
        .PW (PW)
    ) u_picker (
        .i_req        (w_cand_req),
        .i_last_ptr   (r_last_ptr),
        .o_winner     (w_pick),
        .o_winner_idx (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

`ifdef AHB_ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hold_cnt;
    logic          w_limit;
    assign w_limit = (r_hold_cnt == HW'(MAX_HOLD - 1));
`endif

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state    <= ARB_IDLE;
            r_last_ptr <= PW'(CHANNEL_NUM - 1);
            r_sel_addr <= '0;
            r_sel_data <= '0;
`ifdef AHB_ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else if (hready) begin
            r_sel_data <= r_sel_addr;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= ARB_OWN;
                        r_sel_addr <= w_pick;
                        r_last_ptr <= w_pick_idx;
`ifdef AHB_ARB_HOLD_LIMIT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                ARB_OWN: begin
                    if (w_own_lock) begin
                        r_sel_addr <= r_sel_addr;
                    end else if (!w_own_req) begin
                        if (w_pick_valid) begin
                            r_sel_addr <= w_pick;
                            r_last_ptr <= w_pick_idx;
`ifdef AHB_ARB_HOLD_LIMIT_EN
                            r_hold_cnt <= '0;
`endif
                        end else begin
                            r_state    <= ARB_IDLE;
                            r_sel_addr <= '0;
                        end
`ifdef AHB_ARB_HOLD_LIMIT_EN
                    end else if (w_limit && w_pick_valid) begin
                        r_sel_addr <= w_pick;
                        r_last_ptr <= w_pick_idx;
                        r_hold_cnt <= '0;
                    end else if (!w_limit) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign sel_addr    = r_sel_addr;
    assign sel_data    = r_sel_data;
    assign grant_valid = |r_sel_addr;

    a_params: assert property (@(posedge hclk) (CHANNEL_NUM >= 2) && (MAX_HOLD >= 1));
    a_onehot_addr: assert property (@(posedge hclk) disable iff (!hreset_n) $onehot0(r_sel_addr));
    a_onehot_data: assert property (@(posedge hclk) disable iff (!hreset_n) $onehot0(r_sel_data));
    a_frozen: assert property (@(posedge hclk) disable iff (!hreset_n)
        !hready |=> ($stable(r_sel_addr) && $stable(r_sel_data)));
    a_lock: assert property (@(posedge hclk) disable iff (!hreset_n)
        (r_state == ARB_OWN && w_own_lock) |=> $stable(r_sel_addr));

endmodule

// File: tb/tb_ahb_arbiter_slave_3.sv
// tb/tb_ahb_arbiter_slave_3.sv - table-driven bench for ahb_arbiter_slave_3 (both AHB_ARB_HOLD_LIMIT_EN builds)
module tb_ahb_arbiter_slave_3;

    logic       hclk;
    logic       hreset_n;
    logic [1:0] req;
    logic [1:0] lock;
    logic       hready;
    logic [1:0] sel_addr;
    logic [1:0] sel_data;
    logic       grant_valid;

    int n_checks;
    int n_fail;

    ahb_arbiter_slave_3 #(
        .CHANNEL_NUM (2),
        .MAX_HOLD    (4)
    ) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .req         (req),
        .lock        (lock),
        .hready      (hready),
        .sel_addr    (sel_addr),
        .sel_data    (sel_data),
        .grant_valid (grant_valid)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] lock;
        logic       hready;
        logic [1:0] exp_addr;
        logic [1:0] exp_data;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d actual=%b expected=%b", nm, idx, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input int idx, input logic [1:0] ea, input logic [1:0] ed);
        check({nm, "_sel_addr"}, idx, sel_addr, ea);
        check({nm, "_sel_data"}, idx, sel_data, ed);
        check({nm, "_grant_valid"}, idx, {1'b0, grant_valid}, {1'b0, |ea});
    endtask

    task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] lk, input logic hr);
        hreset_n = r;
        req      = rq;
        lock     = lk;
        hready   = hr;
        @(posedge hclk);
        #1;
    endtask

    logic [1:0] prev;
    logic [1:0] ea;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hreset_n = 1'b0;
        req      = 2'b00;
        lock     = 2'b00;
        hready   = 1'b1;
        #1;

        //          rst   req    lock   hrdy  addr   data
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 2'b00};
        tbl[2]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 2'b10};
        tbl[3]  = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10};
        tbl[4]  = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00};
        tbl[5]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00};
        tbl[6]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 2'b00};
        tbl[7]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b01, 2'b00};
        tbl[8]  = '{1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 2'b01};
        tbl[9]  = '{1'b1, 2'b00, 2'b01, 1'b1, 2'b01, 2'b01};
        tbl[10] = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 2'b01};
        tbl[11] = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b10, 2'b01};
        tbl[12] = '{1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 2'b10};
        tbl[13] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01};
        tbl[14] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].lock, tbl[i].hready);
            check_out("vec", i, tbl[i].exp_addr, tbl[i].exp_data);
        end

        // Async reset in the middle of a grant, then channel 0 wins first.
        step(1'b1, 2'b01, 2'b00, 1'b1);
        check_out("pre_rst", 0, 2'b01, 2'b00);
        step(1'b1, 2'b01, 2'b00, 1'b1);
        check_out("pre_rst", 1, 2'b01, 2'b01);
        #2;
        hreset_n = 1'b0;
        #1;
        check_out("async_rst", 0, 2'b00, 2'b00);
        step(1'b1, 2'b11, 2'b00, 1'b1);
        check_out("post_rst", 0, 2'b01, 2'b00);

`ifdef AHB_ARB_HOLD_LIMIT_EN
        prev = 2'b01;
        for (int t = 1; t < 12; t++) begin
            ea = ((t / 4) % 2 == 1) ? 2'b10 : 2'b01;
            step(1'b1, 2'b11, 2'b00, 1'b1);
            check_out("fair", t, ea, prev);
            prev = ea;
        end
        for (int w = 0; w < 3; w++) begin
            step(1'b1, 2'b11, 2'b00, 1'b0);
            check_out("wait", w, 2'b01, 2'b01);
        end
        step(1'b1, 2'b11, 2'b00, 1'b1);
        check_out("wait_handover", 0, 2'b10, 2'b01);
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 2'b11, 2'b00, 1'b1);
            check_out("to_limit", t, 2'b10, 2'b10);
        end
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 2'b11, 2'b10, 1'b1);
            check_out("locked", t, 2'b10, 2'b10);
        end
        step(1'b1, 2'b11, 2'b00, 1'b1);
        check_out("unlock_handover", 0, 2'b01, 2'b10);
`else
        for (int t = 1; t <= 20; t++) begin
            step(1'b1, 2'b11, 2'b00, 1'b1);
            check_out("no_limit", t, 2'b01, 2'b01);
        end
        step(1'b1, 2'b10, 2'b00, 1'b1);
        check_out("drop_owner", 0, 2'b10, 2'b01);
        step(1'b1, 2'b10, 2'b00, 1'b1);
        check_out("drop_owner", 1, 2'b10, 2'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
